// File: rtl/response_analyzer.sv
// Response analyzer for fault simulation campaigns.
// Compares the faulty-circuit response against the fault-free response for
// up to PAT_COUNT patterns per injected fault, drops a fault on the first
// mismatch, and keeps saturating fault/detection tallies across the list.
module response_analyzer #(
  parameter int OUT_BITS  = 1,
  parameter int PAT_COUNT = 16,
  parameter int PAT_BITS  = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OUT_BITS-1:0] CUT_OP,
  input  logic [OUT_BITS-1:0] FF_OP,
  input  logic                FIL_END,
  output logic                FIL_INC,
  output logic                TPG_EN,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] fault_cnt,
  output logic [CNT_BITS-1:0] det_cnt,
  output logic                last_det
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [PAT_BITS-1:0] PAT_LAST = PAT_BITS'(PAT_COUNT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [PAT_BITS-1:0] pat_cnt;
  logic                mis_flag;
  logic                mismatch;
  logic                last_pat;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] val,
                                                  input logic                en);
    if (en && (val != {CNT_BITS{1'b1}}))
      return val + CNT_BITS'(1);
    return val;
  endfunction

  assign mismatch = |(CUT_OP ^ FF_OP);
  assign last_pat = (pat_cnt == PAT_LAST);

  // Outputs decode directly from state so reset forces them low at once.
  assign TPG_EN  = (state == RUN);
  assign busy    = (state == RUN) || (state == INC);
  assign done    = (state == DONE);
  assign FIL_INC = (state == INC) && !FIL_END;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; mismatch and last pattern share the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (mismatch || last_pat) state_nxt = INC;
      INC:  state_nxt = FIL_END ? DONE : RUN;
      DONE: if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pattern counter, sticky mismatch and campaign tallies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_cnt   <= '0;
      mis_flag  <= 1'b0;
      fault_cnt <= '0;
      det_cnt   <= '0;
      last_det  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_cnt   <= '0;
            mis_flag  <= 1'b0;
            fault_cnt <= '0;
            det_cnt   <= '0;
            last_det  <= 1'b0;
          end
        end
        RUN: begin
          pat_cnt  <= pat_cnt + PAT_BITS'(1);
          mis_flag <= mis_flag | mismatch;
        end
        INC: begin
          // Both tallies saturate at the same ceiling, so det_cnt never passes fault_cnt.
          fault_cnt <= sat_inc(fault_cnt, 1'b1);
          det_cnt   <= sat_inc(det_cnt, mis_flag);
          last_det  <= mis_flag;
          pat_cnt   <= '0;
          mis_flag  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_response_analyzer.sv
// Testbench for response_analyzer: randomized fault campaigns checked against
// a per-fault reference (first-mismatch index -> run length, detection).
module tb_response_analyzer;

  localparam int PC = 4;
  localparam int OB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [OB-1:0] cut_op = '0;
  logic [OB-1:0] ff_op = '0;
  logic          fil_end = 1'b0;

  logic          fil_inc, tpg_en, busy, done, last_det;
  logic [15:0]   fault_cnt, det_cnt;
  logic          fil_inc2, tpg_en2, busy2, done2, last_det2;
  logic [1:0]    fault_cnt2, det_cnt2;

  int tests = 0;
  int fails = 0;
  int mis_at[16];

  response_analyzer #(.OUT_BITS(OB), .PAT_COUNT(PC), .PAT_BITS(8), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .CUT_OP(cut_op), .FF_OP(ff_op),
    .FIL_END(fil_end), .FIL_INC(fil_inc), .TPG_EN(tpg_en), .busy(busy),
    .done(done), .fault_cnt(fault_cnt), .det_cnt(det_cnt), .last_det(last_det)
  );

  response_analyzer #(.OUT_BITS(OB), .PAT_COUNT(PC), .PAT_BITS(8), .CNT_BITS(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .CUT_OP(cut_op), .FF_OP(ff_op),
    .FIL_END(fil_end), .FIL_INC(fil_inc2), .TPG_EN(tpg_en2), .busy(busy2),
    .done(done2), .fault_cnt(fault_cnt2), .det_cnt(det_cnt2), .last_det(last_det2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_ops(input bit mis);
    logic [OB-1:0] m;
    ff_op  = OB'($urandom);
    m      = OB'($urandom_range(1, (1 << OB) - 1));
    cut_op = mis ? (ff_op ^ m) : ff_op;
  endtask

  // Runs one full campaign from IDLE using mis_at[] as the per-fault
  // first-mismatch pattern (negative or >= PC means never detected).
  task automatic run_campaign(input int nf, input bit hold_start);
    int exp_f, exp_d, pulses, runlen;
    bit det, is_last;
    exp_f = 0; exp_d = 0; pulses = 0;
    start = 1'b1;
    step();
    tests++;
    if ({fault_cnt, det_cnt, last_det} !== 33'd0) begin
      fails++;
      $display("FAIL start_clear: fault=%0d det=%0d last=%0b expected 0/0/0", fault_cnt, det_cnt, last_det);
    end
    for (int f = 0; f < nf; f++) begin
      det     = (mis_at[f] >= 0) && (mis_at[f] < PC);
      runlen  = det ? mis_at[f] + 1 : PC;
      is_last = (f == nf - 1);
      for (int p = 0; p < runlen; p++) begin
        tests++;
        if ({tpg_en, busy, done, fil_inc, tpg_en2} !== 5'b11001 || det_cnt > fault_cnt) begin
          fails++;
          $display("FAIL run_phase f%0d p%0d: tpg=%0b busy=%0b done=%0b fil_inc=%0b det=%0d fault=%0d expected 1/1/0/0 det<=fault",
                   f, p, tpg_en, busy, done, fil_inc, det_cnt, fault_cnt);
        end
        drive_ops(det && (p == mis_at[f]));
        start   = 1'($urandom);
        fil_end = 1'($urandom);
        step();
      end
      // INC cycle: compare inputs are don't-care here
      drive_ops(1'($urandom));
      fil_end = is_last;
      start   = is_last ? hold_start : 1'($urandom);
      #1;
      tests++;
      if ({tpg_en, busy, done, fil_inc} !== {1'b0, 1'b1, 1'b0, !is_last}) begin
        fails++;
        $display("FAIL inc_phase f%0d: tpg=%0b busy=%0b done=%0b fil_inc=%0b expected 0/1/0/%0b",
                 f, tpg_en, busy, done, fil_inc, !is_last);
      end
      if (fil_inc) pulses++;
      step();
      exp_f++;
      if (det) exp_d++;
      tests++;
      if (fault_cnt !== 16'(exp_f) || det_cnt !== 16'(exp_d) || last_det !== det) begin
        fails++;
        $display("FAIL counts f%0d: fault=%0d det=%0d last=%0b expected %0d/%0d/%0b",
                 f, fault_cnt, det_cnt, last_det, exp_f, exp_d, det);
      end
      tests++;
      if (fault_cnt2 !== 2'(sat(exp_f, 3)) || det_cnt2 !== 2'(sat(exp_d, 3))) begin
        fails++;
        $display("FAIL sat_counts f%0d: fault=%0d det=%0d expected %0d/%0d",
                 f, fault_cnt2, det_cnt2, sat(exp_f, 3), sat(exp_d, 3));
      end
    end
    tests++;
    if ({done, busy, tpg_en} !== 3'b100 || pulses != nf - 1) begin
      fails++;
      $display("FAIL done_state: done=%0b busy=%0b tpg=%0b pulses=%0d expected 1/0/0 pulses=%0d",
               done, busy, tpg_en, pulses, nf - 1);
    end
  endtask

  task automatic expect_idle(input string tag);
    tests++;
    if ({done, busy, tpg_en, fil_inc} !== 4'b0000) begin
      fails++;
      $display("FAIL %s: done=%0b busy=%0b tpg=%0b fil_inc=%0b expected all 0", tag, done, busy, tpg_en, fil_inc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    step(); step();
    tests++;
    if ({busy, done, tpg_en, fil_inc, fault_cnt, det_cnt, last_det} !== 37'd0) begin
      fails++;
      $display("FAIL reset_values: busy=%0b done=%0b tpg=%0b fil_inc=%0b fault=%0d det=%0d last=%0b expected all 0",
               busy, done, tpg_en, fil_inc, fault_cnt, det_cnt, last_det);
    end
    rst = 1'b0;
    step();
    expect_idle("reset_exit_idle");
  endtask

  task automatic test_no_detect();
    for (int i = 0; i < 16; i++) mis_at[i] = -1;
    run_campaign(3, 1'b0);
    step();
    expect_idle("no_detect_back_to_idle");
    tests++;
    if (fault_cnt !== 16'd3 || det_cnt !== 16'd0) begin
      fails++;
      $display("FAIL idle_hold: fault=%0d det=%0d expected 3/0", fault_cnt, det_cnt);
    end
  endtask

  task automatic test_early_detect();
    for (int i = 0; i < 16; i++) mis_at[i] = -1;
    mis_at[0] = 1;
    run_campaign(2, 1'b0);
    step();
    expect_idle("early_detect_idle");
  endtask

  task automatic test_last_pattern();
    for (int i = 0; i < 16; i++) mis_at[i] = -1;
    mis_at[0] = PC - 1;
    run_campaign(1, 1'b0);
    step();
    expect_idle("last_pattern_idle");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) mis_at[i] = $urandom_range(0, PC - 1);
    run_campaign(5, 1'b0);
    step();
    tests++;
    if (fault_cnt2 !== 2'd3 || det_cnt2 !== 2'd3 || fault_cnt !== 16'd5 || det_cnt !== 16'd5) begin
      fails++;
      $display("FAIL saturation: sat fault=%0d det=%0d wide fault=%0d det=%0d expected 3/3 5/5",
               fault_cnt2, det_cnt2, fault_cnt, det_cnt);
    end
  endtask

  task automatic test_held_start();
    logic [15:0] f_snap, d_snap;
    for (int i = 0; i < 16; i++) mis_at[i] = $urandom_range(0, 2 * PC);
    run_campaign(3, 1'b1);
    f_snap = fault_cnt;
    d_snap = det_cnt;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || fault_cnt !== f_snap || det_cnt !== d_snap) begin
        fails++;
        $display("FAIL held_start c%0d: done=%0b busy=%0b fault=%0d det=%0d expected 1/0/%0d/%0d",
                 k, done, busy, fault_cnt, det_cnt, f_snap, d_snap);
      end
    end
    start = 1'b0;
    step();
    expect_idle("held_start_release");
    for (int i = 0; i < 16; i++) mis_at[i] = $urandom_range(0, 2 * PC);
    run_campaign(2, 1'b0);
    step();
    expect_idle("restart_idle");
  endtask

  task automatic test_reset_in_inc();
    start = 1'b1; fil_end = 1'b0;
    step();
    start = 1'b0;
    drive_ops(1'b1);             // fault 0 detected on pattern 0
    step();                      // INC
    step();                      // RUN, fault 1
    tests++;
    if (fault_cnt !== 16'd1 || det_cnt !== 16'd1) begin
      fails++;
      $display("FAIL pre_reset_counts: fault=%0d det=%0d expected 1/1", fault_cnt, det_cnt);
    end
    for (int p = 0; p < PC; p++) begin
      drive_ops(1'b0);
      step();
    end
    fil_end = 1'b0;
    #1;
    tests++;
    if (fil_inc !== 1'b1) begin
      fails++;
      $display("FAIL inc_before_reset: fil_inc=%0b expected 1", fil_inc);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({fil_inc, busy, done, tpg_en, fault_cnt, det_cnt, last_det} !== 37'd0) begin
      fails++;
      $display("FAIL async_reset_inc: fil_inc=%0b busy=%0b done=%0b fault=%0d det=%0d last=%0b expected all 0",
               fil_inc, busy, done, fault_cnt, det_cnt, last_det);
    end
    step();
    rst = 1'b0;
    step();
    expect_idle("after_reset_idle");
    tests++;
    if (fault_cnt !== 16'd0 || det_cnt !== 16'd0) begin
      fails++;
      $display("FAIL after_reset_counts: fault=%0d det=%0d expected 0/0", fault_cnt, det_cnt);
    end
  endtask

  task automatic test_random();
    int nf;
    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(1, 8);
      for (int i = 0; i < 16; i++) mis_at[i] = $urandom_range(0, PC + 2);
      run_campaign(nf, 1'($urandom));
      start = 1'b0;
      step();
      expect_idle("random_idle");
    end
  endtask

  initial begin
    test_reset();
    test_no_detect();
    test_early_detect();
    test_last_pattern();
    test_saturation();
    test_held_start();
    test_reset_in_inc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
